// File: rtl/vgacpu_sim_ctrl.sv
// Simulation controller for the vgacpu Verilator top: DUT reset sequencing, cycle/frame
// counting, button playback and run limits. Optional macro VGACPU_SIM_FINISH_EN adds $finish on done.
module vgacpu_sim_ctrl #(
    parameter int              CNT_W       = 64,
    parameter longint unsigned CYCLE_LIMIT = 1000000,
    parameter int unsigned     FRAME_LIMIT = 0,
    parameter int unsigned     RST_HOLD    = 16,
    parameter int              NUM_BTN     = 4,
    parameter int unsigned     IDLE_LIMIT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               vga_vsync,
    input  logic               btn_valid,
    output logic               btn_ready,
    input  logic [NUM_BTN-1:0] btn_mask,
    input  logic [15:0]        btn_hold,
    output logic               dut_n_rst,
    output logic [NUM_BTN-1:0] buttons,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [31:0]        frame_count,
    output logic               done,
    output logic [1:0]         done_cause
);

    // state   | meaning
    // IDLE    | waiting for start, DUT held in reset
    // RST_DUT | DUT reset asserted for RST_HOLD cycles
    // RUN     | DUT running, counters active, buttons played back
    // DONE    | a limit fired, everything frozen until rst
    typedef enum logic [1:0] {S_IDLE, S_RST_DUT, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CYC_LIM   = CNT_W'(CYCLE_LIMIT);
    localparam logic [31:0]      HOLD_INIT = (RST_HOLD == 0) ? 32'd1 : 32'(RST_HOLD);

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] idle_cnt;
    logic [15:0] press_cnt;
    logic        pressing;
    logic        releasing;
    logic        vsync_q;

    logic        vsync_fall;
    logic        accept;
    logic        cyc_hit;
    logic        frm_hit;
    logic        idl_hit;
    logic        limit_hit;
    logic [1:0]  cause_nxt;

    always_comb begin
        vsync_fall = vsync_q & ~vga_vsync;
        accept     = btn_valid & btn_ready;
        cyc_hit    = (CYCLE_LIMIT != 0) && (cycle_count == CYC_LIM);
        frm_hit    = (FRAME_LIMIT != 0) && (frame_count == FRAME_LIMIT);
        idl_hit    = (IDLE_LIMIT != 0) && (idle_cnt == IDLE_LIMIT);
        limit_hit  = cyc_hit | frm_hit | idl_hit;
        cause_nxt  = 2'd0;
        if (cyc_hit)      cause_nxt = 2'd1;
        else if (frm_hit) cause_nxt = 2'd2;
        else if (idl_hit) cause_nxt = 2'd3;
    end

    // idle_cnt counts RUN cycles since the last accept, including the current one,
    // so an idle timeout lines up with an equal cycle limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            idle_cnt    <= '0;
            press_cnt   <= '0;
            pressing    <= 1'b0;
            releasing   <= 1'b0;
            vsync_q     <= 1'b1;
            dut_n_rst   <= 1'b0;
            buttons     <= '0;
            btn_ready   <= 1'b0;
            cycle_count <= '0;
            frame_count <= '0;
            done        <= 1'b0;
            done_cause  <= 2'd0;
        end else begin
            vsync_q <= vga_vsync;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RST_DUT;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                S_RST_DUT: begin
                    if (hold_cnt <= 32'd1) begin
                        state       <= S_RUN;
                        dut_n_rst   <= 1'b1;
                        btn_ready   <= 1'b1;
                        cycle_count <= CNT_W'(1);
                        idle_cnt    <= 32'd1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (limit_hit) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        done_cause <= cause_nxt;
                        buttons    <= '0;
                        btn_ready  <= 1'b0;
                        pressing   <= 1'b0;
                        releasing  <= 1'b0;
                    end else begin
                        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                        if (vsync_fall && frame_count != '1) frame_count <= frame_count + 1'b1;
                        if (accept) idle_cnt <= 32'd1;
                        else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;

                        if (accept) begin
                            buttons   <= btn_mask;
                            btn_ready <= 1'b0;
                            pressing  <= 1'b1;
                            press_cnt <= (btn_hold == 16'd0) ? 16'd1 : btn_hold;
                        end else if (pressing) begin
                            if (press_cnt <= 16'd1) begin
                                buttons   <= '0;
                                pressing  <= 1'b0;
                                releasing <= 1'b1;
                            end else begin
                                press_cnt <= press_cnt - 1'b1;
                            end
                        end else if (releasing) begin
                            releasing <= 1'b0;
                            btn_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef VGACPU_SIM_FINISH_EN
    always @(posedge clk) begin
        if (!rst && state == S_RUN && limit_hit) begin
            $display("vgacpu_sim_ctrl: done cause=%0d cycles=%0d frames=%0d",
                     cause_nxt, cycle_count, frame_count);
            $finish();
        end
    end
`else
    // Run end is signalled only through done/done_cause.
`endif

endmodule

// File: tb/tb_vgacpu_sim_ctrl.sv
// Directed bench for vgacpu_sim_ctrl: a vector table for reset sequencing and button
// handshakes, plus hand sequences for the cycle, frame, idle, saturation and rst cases.
module tb_vgacpu_sim_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        vga_vsync = 1'b1;
    logic        btn_valid = 1'b0;
    logic [3:0]  btn_mask = '0;
    logic [15:0] btn_hold = '0;

    logic        ready_a, ready_b, ready_c;
    logic        nrst_a, nrst_b, nrst_c;
    logic [3:0]  buttons_a, buttons_b, buttons_c;
    logic [63:0] cc_a;
    logic [7:0]  cc_b;
    logic [15:0] cc_c;
    logic [31:0] fc_a, fc_b, fc_c;
    logic        done_a, done_b, done_c;
    logic [1:0]  cause_a, cause_b, cause_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vgacpu_sim_ctrl #(.CNT_W(64), .CYCLE_LIMIT(100), .FRAME_LIMIT(3), .RST_HOLD(4),
                      .NUM_BTN(4), .IDLE_LIMIT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vga_vsync(vga_vsync),
        .btn_valid(btn_valid), .btn_ready(ready_a), .btn_mask(btn_mask), .btn_hold(btn_hold),
        .dut_n_rst(nrst_a), .buttons(buttons_a), .cycle_count(cc_a), .frame_count(fc_a),
        .done(done_a), .done_cause(cause_a));

    vgacpu_sim_ctrl #(.CNT_W(8), .CYCLE_LIMIT(0), .FRAME_LIMIT(3), .RST_HOLD(1),
                      .NUM_BTN(4), .IDLE_LIMIT(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vga_vsync(vga_vsync),
        .btn_valid(btn_valid), .btn_ready(ready_b), .btn_mask(btn_mask), .btn_hold(btn_hold),
        .dut_n_rst(nrst_b), .buttons(buttons_b), .cycle_count(cc_b), .frame_count(fc_b),
        .done(done_b), .done_cause(cause_b));

    vgacpu_sim_ctrl #(.CNT_W(16), .CYCLE_LIMIT(0), .FRAME_LIMIT(0), .RST_HOLD(2),
                      .NUM_BTN(4), .IDLE_LIMIT(20)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .vga_vsync(vga_vsync),
        .btn_valid(btn_valid), .btn_ready(ready_c), .btn_mask(btn_mask), .btn_hold(btn_hold),
        .dut_n_rst(nrst_c), .buttons(buttons_c), .cycle_count(cc_c), .frame_count(fc_c),
        .done(done_c), .done_cause(cause_c));

    typedef struct {
        logic        start;
        logic        valid;
        logic [3:0]  mask;
        logic [15:0] hold;
        logic        nrst;
        logic [3:0]  btn;
        logic        ready;
        logic [63:0] cc;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic s, input logic v, input logic [3:0] m,
                                input logic [15:0] h, input logic n, input logic [3:0] b,
                                input logic r, input logic [63:0] c);
        vec_t x;
        x.start = s; x.valid = v; x.mask = m; x.hold = h;
        x.nrst = n; x.btn = b; x.ready = r; x.cc = c;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cc_of(input int w);
        if (w == 0) return cc_a;
        if (w == 1) return 64'(cc_b);
        return 64'(cc_c);
    endfunction

    // Polls at negedges until the chosen instance's cycle_count equals t.
    task automatic wait_cc(input int w, input logic [63:0] t);
        int n = 0;
        while (cc_of(w) != t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_cc inst%0d: actual=%0d expected=%0d", w, cc_of(w), t);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        btn_valid = 1'b0; vga_vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input int w);
        @(negedge clk);
        if (w == 0) start_a = 1'b1; else if (w == 1) start_b = 1'b1; else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic frame_at(input int w, input logic [63:0] t);
        wait_cc(w, t);
        vga_vsync = 1'b0;
        @(negedge clk);
        vga_vsync = 1'b1;
    endtask

    initial begin
        // row: start valid mask hold | n_rst buttons ready cycle_count
        vecs[0]  = mk(0, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[1]  = mk(0, 1, 4'b1111, 16'd3, 0, 4'b0000, 0, 64'd0);
        vecs[2]  = mk(1, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[3]  = mk(0, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[4]  = mk(1, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[5]  = mk(0, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[6]  = mk(0, 0, 4'b0000, 16'd0, 0, 4'b0000, 0, 64'd0);
        vecs[7]  = mk(0, 0, 4'b0000, 16'd0, 1, 4'b0000, 1, 64'd1);
        vecs[8]  = mk(0, 1, 4'b0101, 16'd5, 1, 4'b0000, 1, 64'd2);
        vecs[9]  = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0101, 0, 64'd3);
        vecs[10] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0101, 0, 64'd4);
        vecs[11] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0101, 0, 64'd5);
        vecs[12] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0101, 0, 64'd6);
        vecs[13] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0101, 0, 64'd7);
        vecs[14] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0000, 0, 64'd8);
        vecs[15] = mk(0, 1, 4'b1010, 16'd0, 1, 4'b0000, 1, 64'd9);
        vecs[16] = mk(0, 0, 4'b0000, 16'd0, 1, 4'b1010, 0, 64'd10);
        vecs[17] = mk(0, 0, 4'b0000, 16'd0, 1, 4'b0000, 0, 64'd11);
        vecs[18] = mk(0, 0, 4'b0000, 16'd0, 1, 4'b0000, 1, 64'd12);
        vecs[19] = mk(0, 0, 4'b0000, 16'd0, 1, 4'b0000, 1, 64'd13);

        // reset values while rst is held
        @(negedge clk);
        @(negedge clk);
        chk("rst n_rst", 64'(nrst_a), 64'd0);
        chk("rst buttons", 64'(buttons_a), 64'd0);
        chk("rst ready", 64'(ready_a), 64'd0);
        chk("rst cycle_count", cc_a, 64'd0);
        chk("rst frame_count", 64'(fc_a), 64'd0);
        chk("rst done", 64'(done_a), 64'd0);
        chk("rst done_cause", 64'(cause_a), 64'd0);
        rst = 1'b0;

        // reset sequencing and button handshakes on instance A
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("row%0d n_rst", k), 64'(nrst_a), 64'(vecs[k].nrst));
            chk($sformatf("row%0d buttons", k), 64'(buttons_a), 64'(vecs[k].btn));
            chk($sformatf("row%0d ready", k), 64'(ready_a), 64'(vecs[k].ready));
            chk($sformatf("row%0d cycle_count", k), cc_a, vecs[k].cc);
            start_a = vecs[k].start; btn_valid = vecs[k].valid;
            btn_mask = vecs[k].mask; btn_hold = vecs[k].hold;
        end

        // cycle limit
        wait_cc(0, 64'd100);
        chk("cyc pre done", 64'(done_a), 64'd0);
        btn_valid = 1'b1; btn_mask = 4'b1111; btn_hold = 16'd2;
        @(negedge clk);
        chk("cyc done", 64'(done_a), 64'd1);
        chk("cyc cause", 64'(cause_a), 64'd1);
        chk("cyc frozen count", cc_a, 64'd100);
        chk("cyc n_rst high", 64'(nrst_a), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("done ready", 64'(ready_a), 64'd0);
        chk("done buttons", 64'(buttons_a), 64'd0);
        chk("done frames", 64'(fc_a), 64'd0);
        btn_valid = 1'b0;

        // rst in the middle of a press, on the cycle both limits would fire
        do_reset();
        pulse_start(0);
        frame_at(0, 64'd20);
        chk("f1 count", 64'(fc_a), 64'd1);
        frame_at(0, 64'd40);
        chk("f2 count", 64'(fc_a), 64'd2);
        wait_cc(0, 64'd95);
        chk("press ready", 64'(ready_a), 64'd1);
        btn_valid = 1'b1; btn_mask = 4'b1111; btn_hold = 16'd10;
        @(negedge clk);
        btn_valid = 1'b0;
        chk("press buttons", 64'(buttons_a), 64'd15);
        frame_at(0, 64'd99);
        chk("both f3", 64'(fc_a), 64'd3);
        chk("both press active", 64'(buttons_a), 64'd15);
        chk("both pre done", 64'(done_a), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst n_rst", 64'(nrst_a), 64'd0);
        chk("midrst buttons", 64'(buttons_a), 64'd0);
        chk("midrst ready", 64'(ready_a), 64'd0);
        chk("midrst cycle_count", cc_a, 64'd0);
        chk("midrst frame_count", 64'(fc_a), 64'd0);
        chk("midrst done", 64'(done_a), 64'd0);
        chk("midrst cause", 64'(cause_a), 64'd0);
        rst = 1'b0;
        pulse_start(0);
        frame_at(0, 64'd20);
        frame_at(0, 64'd40);
        frame_at(0, 64'd99);
        chk("simul frame", 64'(fc_a), 64'd3);
        chk("simul pre done", 64'(done_a), 64'd0);
        @(negedge clk);
        chk("simul done", 64'(done_a), 64'd1);
        chk("simul cause", 64'(cause_a), 64'd1);
        chk("simul cycles", cc_a, 64'd100);

        // frame limit on instance B
        do_reset();
        pulse_start(1);
        wait_cc(1, 64'd50);
        vga_vsync = 1'b0;
        chk("fl before edge", 64'(fc_b), 64'd0);
        @(negedge clk);
        vga_vsync = 1'b1;
        chk("fl frame1", 64'(fc_b), 64'd1);
        frame_at(1, 64'd150);
        chk("fl frame2", 64'(fc_b), 64'd2);
        frame_at(1, 64'd250);
        chk("fl frame3", 64'(fc_b), 64'd3);
        chk("fl pre done", 64'(done_b), 64'd0);
        @(negedge clk);
        chk("fl done", 64'(done_b), 64'd1);
        chk("fl cause", 64'(cause_b), 64'd2);
        chk("fl frozen cycles", 64'(cc_b), 64'd251);
        pulse_start(1);
        @(negedge clk);
        chk("fl start ignored done", 64'(done_b), 64'd1);
        chk("fl start ignored n_rst", 64'(nrst_b), 64'd1);
        chk("fl still frozen", 64'(cc_b), 64'd251);
        chk("fl frames frozen", 64'(fc_b), 64'd3);

        // cycle_count saturation with no cycle limit
        do_reset();
        pulse_start(1);
        wait_cc(1, 64'd255);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("sat cycles", 64'(cc_b), 64'd255);
        chk("sat done", 64'(done_b), 64'd0);

        // idle timeout on instance C
        do_reset();
        pulse_start(2);
        wait_cc(2, 64'd20);
        chk("idle pre done", 64'(done_c), 64'd0);
        @(negedge clk);
        chk("idle done", 64'(done_c), 64'd1);
        chk("idle cause", 64'(cause_c), 64'd3);
        chk("idle cycles", 64'(cc_c), 64'd20);

        do_reset();
        pulse_start(2);
        wait_cc(2, 64'd15);
        chk("idle2 ready", 64'(ready_c), 64'd1);
        btn_valid = 1'b1; btn_mask = 4'b0011; btn_hold = 16'd2;
        @(negedge clk);
        btn_valid = 1'b0;
        chk("idle2 buttons", 64'(buttons_c), 64'd3);
        chk("idle A no press", 64'(buttons_a), 64'd0);
        chk("idle A no ready", 64'(ready_a), 64'd0);
        wait_cc(2, 64'd35);
        chk("idle2 pre done", 64'(done_c), 64'd0);
        @(negedge clk);
        chk("idle2 done", 64'(done_c), 64'd1);
        chk("idle2 cause", 64'(cause_c), 64'd3);
        chk("idle2 cycles", 64'(cc_c), 64'd35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
